// File: rtl/led_pkg.sv
// Shared constants for the button reader.
//   STEP_DEFAULT  : debounce stability window in clock cycles
//   WIDTH_DEFAULT : number of button inputs
//   DEPTH_DEFAULT : event FIFO entries (power of two)
//   IDX_W         : index width for the default button count
//   idx_width()   : index width for any count, never narrower than 1 bit
package led_pkg;

  localparam int STEP_DEFAULT  = 10;
  localparam int WIDTH_DEFAULT = 8;
  localparam int DEPTH_DEFAULT = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_width(WIDTH_DEFAULT);

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer followed by a stability counter.
// Ports:
//   clk_i   : clock, all logic on posedge
//   rst_i   : synchronous active-high reset
//   btn_i   : raw asynchronous button level (1 = pressed)
//   state_o : debounced level, registered
//   rise_o  : one-cycle pulse, high in the cycle after state_o goes 0->1
module btn_debounce
  import led_pkg::*;
#(
  parameter int STEP = STEP_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic state_o,
  output logic rise_o
);

  logic        sync1_q, sync2_q;
  logic        state_q, state_d;
  logic        rise_q, rise_d;
  logic [31:0] cnt_q, cnt_d;

  // The counter only grows while the synced level disagrees with state_q and
  // clears on reaching STEP-1, so it can never wrap.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d = state_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != state_q) begin
      if (cnt_q == 32'(STEP - 1)) begin
        state_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, which is what makes the 2-flop chain work.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/btn_reader.sv
// Debounced button reader with a press-event FIFO.
// Each button is debounced by its own btn_debounce. Presses (0->1 of the
// debounced level) set a pending bit; the lowest pending index is moved into
// the FIFO, one per cycle, whenever the FIFO has room.
// Ports:
//   CLK       : clock, all logic on posedge
//   RST       : synchronous active-high reset
//   BTN       : raw button levels, WIDTH bits, 1 = pressed
//   STATE     : debounced button levels, registered
//   EVT_VALID : FIFO non-empty
//   EVT_DATA  : index of the oldest press event (valid with EVT_VALID)
//   EVT_READY : consumer accepts the head event
//   OVF       : sticky, a press hit an already pending bit
module btn_reader
  import led_pkg::*;
#(
  parameter int STEP  = STEP_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [WIDTH-1:0]            BTN,
  output logic [WIDTH-1:0]            STATE,
  output logic                        EVT_VALID,
  output logic [idx_width(WIDTH)-1:0] EVT_DATA,
  input  logic                        EVT_READY,
  output logic                        OVF
);

  localparam int IW = idx_width(WIDTH);
  localparam int PW = idx_width(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] state_w, rise_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    btn_debounce #(.STEP(STEP)) u_deb (
      .clk_i   (CLK),
      .rst_i   (RST),
      .btn_i   (BTN[i]),
      .state_o (state_w[i]),
      .rise_o  (rise_w[i])
    );
  end

  logic [WIDTH-1:0] pending_q, pending_d;
  logic             ovf_q, ovf_d;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [IW-1:0]    mem [DEPTH];
  logic [IW-1:0]    sel_idx;
  logic             full, wr_en, rd_en;

  // Lowest set pending bit; scanning downward lets the lowest index win.
  always_comb begin
    sel_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = IW'(i);
    end
  end

  // A full FIFO blocks the write even if a pop frees a slot this same edge.
  assign full  = (count_q == CW'(DEPTH));
  assign wr_en = (|pending_q) && !full;
  assign rd_en = (count_q != '0) && EVT_READY;

  always_comb begin
    pending_d = pending_q;
    if (wr_en) pending_d[sel_idx] = 1'b0;
    // New presses are applied after the clear, so a press landing on the bit
    // being drained is kept as a new pending event rather than dropped.
    pending_d = pending_d | rise_w;
    ovf_d     = ovf_q | (|(rise_w & pending_q));

    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pending_q <= '0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // has been written, because EVT_VALID is derived from the reset occupancy.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr_q] <= sel_idx;
  end

  assign STATE     = state_w;
  assign EVT_VALID = (count_q != '0);
  assign EVT_DATA  = mem[rd_ptr_q];
  assign OVF       = ovf_q;

endmodule

// File: doc/btn_reader.md
BTN_READER -- requirements
Module: btn_reader

Interface
REQ-001 Parameter STEP, default 10, debounce stability window in CLK cycles, legal range >= 2.
REQ-002 Parameter WIDTH, default 8, number of button inputs (one per LED bit).
REQ-003 Parameter DEPTH, default 4, event FIFO entries (power of two).
REQ-004 CLK  input  1  single clock; all logic on posedge CLK.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 BTN  input  WIDTH  raw asynchronous button levels, 1 = pressed.
REQ-007 STATE  output  WIDTH  debounced button levels, registered.
REQ-008 EVT_VALID  output  1  FIFO non-empty.
REQ-009 EVT_DATA  output  $clog2(WIDTH)  index of the oldest press event; valid only while EVT_VALID = 1.
REQ-010 EVT_READY  input  1  consumer accepts the head event.
REQ-011 OVF  output  1  sticky flag; a press event was merged or lost.

Function
REQ-012 Each BTN bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Per bit, a counter SHALL increment while the synced bit differs from the STATE bit, and SHALL clear to 0 when they match.
REQ-014 When the counter equals STEP-1 while the mismatch persists, STATE SHALL take the synced value and the counter SHALL clear in the same cycle.
REQ-015 The counter SHALL be 32 bits wide and SHALL never wrap, because it clears at STEP-1.
REQ-016 Any glitch shorter than STEP synced cycles SHALL leave STATE unchanged.
REQ-017 A STATE 0->1 transition on bit i SHALL set pending[i] at the next edge; a 1->0 transition SHALL generate no event.
REQ-018 A 0->1 transition on bit i while pending[i] is already 1 SHALL set OVF; the two presses merge into one event.
REQ-019 Each cycle, when pending != 0 and the FIFO is not full, the lowest set pending index SHALL be written to the FIFO and its pending bit cleared at the same edge.
REQ-020 Only one FIFO write SHALL occur per cycle; when pending bits are set simultaneously they are written in ascending index order on consecutive cycles.
REQ-021 A pop SHALL occur exactly when EVT_VALID = 1 and EVT_READY = 1; EVT_DATA SHALL advance to the next entry at that edge.
REQ-022 A write while the FIFO is full SHALL be blocked, even if a pop happens in the same cycle; the pending bit SHALL be retained and nothing is lost.
REQ-023 A simultaneous write and pop when the FIFO is not full SHALL both occur, and the occupancy SHALL be unchanged.
REQ-024 EVT_VALID and EVT_DATA SHALL be held stable while EVT_VALID = 1 and EVT_READY = 0.
REQ-025 Latency: STATE rises at edge N, pending is set at N+1, and with an empty FIFO EVT_VALID = 1 after edge N+2.
REQ-026 OVF SHALL be cleared only by RST.

Reset
REQ-027 While RST = 1 at a posedge, the following SHALL clear to 0: synchronizers, counters, STATE, pending, FIFO pointers and occupancy, and OVF; EVT_VALID therefore = 0.
REQ-028 A RST asserted mid-debounce or with a non-empty FIFO SHALL discard all in-flight events; no event SHALL appear afterwards until a new STEP-stable press occurs.
REQ-029 After RST, a BTN bit already held high SHALL be debounced as a fresh press, STEP+2 cycles later.

Structure
REQ-030 Shared package led_pkg SHALL hold the STEP default, WIDTH default, DEPTH default, and the index-width constant.
REQ-031 Per-bit synchronizer plus debounce counter SHALL be one sub-module, btn_debounce, instantiated WIDTH times; pending, priority select, FIFO and OVF stay in btn_reader.

Verification
REQ-032 STEP=10; BTN[3] held 1 from cycle 0 -> STATE[3] = 1 after edge 12; EVT_VALID = 1 with EVT_DATA = 3 after edge 14.
REQ-033 BTN[0] pulsed high for 8 cycles -> STATE and EVT_VALID stay 0 throughout.
REQ-034 BTN[5], BTN[1] and BTN[6] rise in the same cycle, EVT_READY = 1 -> EVT_DATA sequence 1, 5, 6 on consecutive cycles.
REQ-035 EVT_READY = 0, presses on bits 0..5 -> FIFO holds 0,1,2,3; pending holds {4,5}; OVF = 0; raising EVT_READY then yields 0,1,2,3,4,5 in order.
REQ-036 Bit 2 pressed, released and pressed again while pending[2] is blocked by a full FIFO -> OVF = 1 and exactly one index-2 event is delivered.
REQ-037 RST asserted for 1 cycle with 3 queued events -> EVT_VALID = 0 and OVF = 0 after that edge, and no stale events follow.
